dht11_meas_scheduler: RTL and testbench

// - Sequences the DHT11 measurement controller: merges manual and periodic (auto) requests,

---
 rtl/dht11_pkg.sv | 24 ++
 rtl/dht11_meas_scheduler_tick_counter.sv | 44 ++++
 rtl/dht11_meas_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_dht11_meas_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 measurement scheduler.
// Contents:
//   dht_state_t   - scheduler FSM states
//   DHT_*         - default parameter values for the scheduler
//   cnt_width()   - register width needed to hold 0..modulus-1 (minimum 1 bit)
package dht11_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } dht_state_t;

  localparam int DHT_PERIOD_S    = 5;
  localparam int DHT_MIN_GAP_S   = 2;
  localparam int DHT_MAX_RETRY   = 3;
  localparam int DHT_TIMEOUT_CYC = 5_000_000;

  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/dht11_meas_scheduler_tick_counter.sv
// sched_tick_counter: modulo-MODULUS counter advanced by a tick pulse.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high
//   clear  in  synchronous clear; holds the count at 0 and suppresses wrap
//   tick   in  advance enable (one step per cycle it is high)
//   wrap   out combinational; high in the tick cycle that takes the count
//              from MODULUS-1 back to 0
module sched_tick_counter
  import dht11_pkg::*;
#(
  parameter int MODULUS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic wrap
);

  localparam int W = cnt_width(MODULUS);
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] count;

  assign wrap = tick && !clear && (count == LAST);

  // Count ticks, folding back to zero after the last value so the wrap
  // pulse repeats every MODULUS ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dht11_meas_scheduler.sv
// dht11_meas_scheduler: decides when the DHT11 controller runs a frame.
// Merges manual and periodic requests into a one-deep pending flag, issues a
// single start pulse per attempt, retries failed reads, and enforces a
// sec_tick-based hold-off after every attempt.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   sec_tick             1 Hz one-cycle pulse
//   auto_en              level, enables periodic measurements
//   man_req              one-cycle manual request
//   dht_start            one-cycle start pulse to the controller
//   dht_done             controller finished a frame (one cycle)
//   dht_valid            checksum OK, meaningful only with dht_done
//   rh_in, temp_in       frame bytes, meaningful only with dht_done
//   rh_data, temp_data   last good reading
//   data_valid           one-cycle pulse, rh_data/temp_data just updated
//   err                  one-cycle pulse, measurement failed after all retries
//   busy                 high whenever the FSM is not IDLE
//   fail_cnt             failed measurements, saturating at 255
module dht11_meas_scheduler #(
  parameter int PERIOD_S    = dht11_pkg::DHT_PERIOD_S,
  parameter int MIN_GAP_S   = dht11_pkg::DHT_MIN_GAP_S,
  parameter int MAX_RETRY   = dht11_pkg::DHT_MAX_RETRY,
  parameter int TIMEOUT_CYC = dht11_pkg::DHT_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       auto_en,
  input  logic       man_req,
  output logic       dht_start,
  input  logic       dht_done,
  input  logic       dht_valid,
  input  logic [7:0] rh_in,
  input  logic [7:0] temp_in,
  output logic [7:0] rh_data,
  output logic [7:0] temp_data,
  output logic       data_valid,
  output logic       err,
  output logic       busy,
  output logic [7:0] fail_cnt
);

  import dht11_pkg::*;

  localparam int TMO_W   = cnt_width(TIMEOUT_CYC);
  localparam int RETRY_W = cnt_width(MAX_RETRY + 1);

  localparam logic [TMO_W-1:0]   TMO_LAST      = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT   = RETRY_W'(MAX_RETRY);

  dht_state_t         state;
  logic               pending;
  logic               retry_flag;
  logic [RETRY_W-1:0] retry_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  logic period_wrap;
  logic gap_wrap;
  logic new_req;
  logic leave_idle;
  logic good_read;
  logic attempt_failed;

  // The period counter keeps running through busy states so the auto rate
  // does not drift with measurement length; dropping auto_en parks it at 0.
  sched_tick_counter #(.MODULUS(PERIOD_S)) u_period_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (!auto_en),
    .tick  (sec_tick && auto_en),
    .wrap  (period_wrap)
  );

  // The hold-off counter only sees ticks while in GAP and restarts from 0
  // on every entry.
  sched_tick_counter #(.MODULUS(MIN_GAP_S)) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state != GAP),
    .tick  (sec_tick && (state == GAP)),
    .wrap  (gap_wrap)
  );

  // A request arriving directly in IDLE is acted on in the same cycle so the
  // start pulse follows it by exactly one clock.
  assign new_req        = man_req || period_wrap;
  assign leave_idle     = (state == IDLE) && (pending || new_req);
  assign good_read      = (state == WAIT) && dht_done && dht_valid;
  assign attempt_failed = (state == WAIT) &&
                          ((dht_done && !dht_valid) || (!dht_done && (tmo_cnt == TMO_LAST)));

  // One-deep request latch: anything arriving while a request is already
  // outstanding (or in the cycle it is taken) merges into it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (leave_idle) begin
      pending <= 1'b0;
    end else if (new_req) begin
      pending <= 1'b1;
    end
  end

  // Main sequencer with registered outputs. Pulse outputs default low every
  // cycle and are raised only on the transition that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dht_start  <= 1'b0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      rh_data    <= 8'd0;
      temp_data  <= 8'd0;
      fail_cnt   <= 8'd0;
      retry_cnt  <= '0;
      retry_flag <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      dht_start  <= 1'b0;
      data_valid <= 1'b0;
      err        <= 1'b0;

      case (state)
        IDLE: begin
          if (leave_idle) begin
            state     <= START;
            dht_start <= 1'b1;
            busy      <= 1'b1;
          end
        end

        START: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end

        WAIT: begin
          if (good_read) begin
            rh_data    <= rh_in;
            temp_data  <= temp_in;
            data_valid <= 1'b1;
            retry_cnt  <= '0;
            state      <= GAP;
          end else if (attempt_failed) begin
            if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt  <= retry_cnt + 1'b1;
              retry_flag <= 1'b1;
            end else begin
              err       <= 1'b1;
              retry_cnt <= '0;
              if (fail_cnt != 8'hFF) begin
                fail_cnt <= fail_cnt + 8'd1;
              end
            end
            state <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        GAP: begin
          // A pending retry goes straight back out; a queued request is
          // picked up from IDLE on the following cycle.
          if (gap_wrap) begin
            if (retry_flag) begin
              retry_flag <= 1'b0;
              dht_start  <= 1'b1;
              state      <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_meas_scheduler.sv
// Self-checking bench for dht11_meas_scheduler.
// Stimulus pushes each expected start/data/err event (with the cycle it must
// appear in) into a queue; a negedge monitor pops and compares whenever the
// DUT pulses one of those outputs. Level outputs are checked directly.
module tb_dht11_meas_scheduler;

  localparam int PERIOD_S    = 3;
  localparam int MIN_GAP_S   = 1;
  localparam int MAX_RETRY   = 2;
  localparam int TIMEOUT_CYC = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       auto_en = 1'b0;
  logic       man_req = 1'b0;
  logic       dht_done = 1'b0;
  logic       dht_valid = 1'b0;
  logic [7:0] rh_in = 8'd0;
  logic [7:0] temp_in = 8'd0;
  logic       dht_start;
  logic [7:0] rh_data;
  logic [7:0] temp_data;
  logic       data_valid;
  logic       err;
  logic       busy;
  logic [7:0] fail_cnt;

  dht11_meas_scheduler #(
    .PERIOD_S    (PERIOD_S),
    .MIN_GAP_S   (MIN_GAP_S),
    .MAX_RETRY   (MAX_RETRY),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sec_tick   (sec_tick),
    .auto_en    (auto_en),
    .man_req    (man_req),
    .dht_start  (dht_start),
    .dht_done   (dht_done),
    .dht_valid  (dht_valid),
    .rh_in      (rh_in),
    .temp_in    (temp_in),
    .rh_data    (rh_data),
    .temp_data  (temp_data),
    .data_valid (data_valid),
    .err        (err),
    .busy       (busy),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef enum {EV_START, EV_DATA, EV_ERR} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    int         cycle;
    logic [7:0] rh;
    logic [7:0] temp;
    logic [7:0] fcnt;
  } exp_t;

  exp_t exp_q[$];

  function automatic void pushExp(ev_kind_t k, int c, logic [7:0] rh, logic [7:0] t, logic [7:0] f);
    exp_t e;
    e.kind  = k;
    e.cycle = c;
    e.rh    = rh;
    e.temp  = t;
    e.fcnt  = f;
    exp_q.push_back(e);
  endfunction

  // Monitor: every start/data/err pulse must match the oldest expectation
  // in kind, cycle and payload.
  always @(negedge clk) begin
    ev_kind_t got;
    exp_t     e;
    logic     ok;
    if (!reset && (dht_start || data_valid || err)) begin
      got = dht_start ? EV_START : (data_valid ? EV_DATA : EV_ERR);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event: got %s at cycle %0d, required no event", got.name(), cyc);
      end else begin
        e  = exp_q.pop_front();
        ok = (e.kind == got) && (e.cycle == cyc);
        if (got == EV_DATA) ok = ok && (rh_data == e.rh) && (temp_data == e.temp);
        if (got == EV_ERR)  ok = ok && (fail_cnt == e.fcnt);
        if (!ok) begin
          errors++;
          $display("[TB] FAIL event: got %s cyc=%0d rh=%02h temp=%02h fail_cnt=%0d, required %s cyc=%0d rh=%02h temp=%02h fail_cnt=%0d",
                   got.name(), cyc, rh_data, temp_data, fail_cnt,
                   e.kind.name(), e.cycle, e.rh, e.temp, e.fcnt);
        end
      end
    end
  end

  // Drive one cycle of inputs, then return #1 after the sampling edge with
  // all pulse inputs back low.
  task automatic applyStimulus(input logic man, input logic sec, input logic done,
                               input logic valid, input logic [7:0] rh, input logic [7:0] temp);
    man_req   = man;
    sec_tick  = sec;
    dht_done  = done;
    dht_valid = valid;
    rh_in     = rh;
    temp_in   = temp;
    @(posedge clk);
    #1;
    man_req   = 1'b0;
    sec_tick  = 1'b0;
    dht_done  = 1'b0;
    dht_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_dht_start", dht_start, 0);
    checkOutput("reset_data_valid", data_valid, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rh_data", rh_data, 0);
    checkOutput("reset_temp_data", temp_data, 0);
    checkOutput("reset_fail_cnt", fail_cnt, 0);
    reset = 1'b0;
    idle(2);

    // Manual read, done 20 cycles after the request
    $display("[TB] manual read");
    pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("man_busy_after_start", busy, 1);
    idle(19);
    pushExp(EV_DATA, cyc + 1, 8'h37, 8'h19, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h37, 8'h19);
    checkOutput("man_rh_data", rh_data, 8'h37);
    checkOutput("man_temp_data", temp_data, 8'h19);
    idle(3);
    checkOutput("man_busy_in_gap", busy, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("man_busy_after_gap", busy, 0);

    // Periodic reads: one start on every third sec_tick
    $display("[TB] auto reads");
    auto_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(4);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(4);
      pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(3);
      pushExp(EV_DATA, cyc + 1, 8'(8'h40 + p), 8'(8'h10 + p), 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h40 + p), 8'(8'h10 + p));
      idle(3);
    end
    auto_en = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(5);
    checkOutput("auto_busy_end", busy, 0);
    checkOutput("auto_rh_last", rh_data, 8'h42);

    // Two bad checksums then a good read
    $display("[TB] retry then success");
    pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE, 8'hEE);
    idle(2);
    pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE, 8'hEE);
    idle(2);
    pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    pushExp(EV_DATA, cyc + 1, 8'h2A, 8'h15, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h2A, 8'h15);
    idle(2);
    checkOutput("retry_fail_cnt", fail_cnt, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(2);
    checkOutput("retry_busy_end", busy, 0);

    // No answer at all: each attempt times out after exactly TIMEOUT_CYC
    // WAIT cycles (a tick in the last WAIT cycle must not end the hold-off).
    $display("[TB] timeouts");
    pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int a = 0; a < MAX_RETRY; a++) begin
      idle(TIMEOUT_CYC);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    pushExp(EV_ERR, cyc + TIMEOUT_CYC + 1, 8'h00, 8'h00, 8'd1);
    idle(TIMEOUT_CYC + 2);
    checkOutput("tmo_fail_cnt", fail_cnt, 1);
    checkOutput("tmo_rh_kept", rh_data, 8'h2A);
    checkOutput("tmo_temp_kept", temp_data, 8'h15);
    checkOutput("tmo_busy_in_gap", busy, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(1);
    checkOutput("tmo_busy_end", busy, 0);

    // Manual request during WAIT is served once after the hold-off
    $display("[TB] request merging");
    pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(2);
    pushExp(EV_DATA, cyc + 1, 8'h33, 8'h22, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 8'h22);
    idle(2);
    pushExp(EV_START, cyc + 2, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    pushExp(EV_DATA, cyc + 1, 8'h34, 8'h23, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h34, 8'h23);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(20);
    checkOutput("merge_busy_end", busy, 0);

    // Auto wrap and manual request in the same cycle give one start
    auto_en = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    pushExp(EV_DATA, cyc + 1, 8'h35, 8'h24, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h35, 8'h24);
    auto_en = 1'b0;
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(20);
    checkOutput("coincident_busy_end", busy, 0);

    // Reset during WAIT abandons the read; stray dones are ignored
    $display("[TB] reset mid-measurement");
    pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rh_data", rh_data, 0);
    checkOutput("rst_temp_data", temp_data, 0);
    checkOutput("rst_fail_cnt", fail_cnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 8'h66);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 8'h66);
    idle(20);
    checkOutput("rst_rh_after_done", rh_data, 0);
    checkOutput("rst_busy_after_done", busy, 0);
    pushExp(EV_START, cyc + 1, 8'h00, 8'h00, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    pushExp(EV_DATA, cyc + 1, 8'h12, 8'h34, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    checkOutput("final_busy", busy, 0);

    checkOutput("exp_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
